// File: rtl/divider_sequential_if.sv
// Handshake/data bundle for the sequential IEEE-754 single-precision divider.
// Master drives operands and start; slave returns status, result and flags.
interface divider_sequential_if;
  // start is sampled only while busy=0; busy stays high from the cycle after acceptance
  // until done; done is a one-cycle pulse, and result/flags hold until the next done.
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;

  modport master (
    output start, A, B,
    input  busy, done, result, overflow, underflow, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, result, overflow, underflow, div_by_zero
  );
endinterface

// File: rtl/divider_sequential.sv
// Multi-cycle IEEE-754 single divider: restoring mantissa division, 26 quotient bits.
// Define DIV_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module divider_sequential (
  input  logic                        clk,
  input  logic                        rst_n,
  divider_sequential_if.slave         dif,
  output logic [2:0]                  dbg_state
);

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, DONE} state_t;

  state_t             state;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic               sign;
  logic [23:0]        mant_b;
  logic signed [9:0]  exp_r;
  logic [25:0]        rem;
  logic [25:0]        quo;
  logic [4:0]         cnt;
  logic [31:0]        res_r;
  logic [2:0]         flags_r;

  logic               unpack_sign;
  logic               a_zero;
  logic               b_zero;
  logic signed [9:0]  exp_calc;
  logic [25:0]        rem_diff;
  logic               rem_ge;

  logic [22:0]        mant_n;
  logic signed [9:0]  exp_n;
  logic [22:0]        mant_f;
  logic signed [9:0]  exp_f;
  logic [31:0]        norm_res;
  logic [2:0]         norm_flags;
`ifdef DIV_ROUND_NEAREST_EN
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic               carry;
`endif

  assign dbg_state   = state;
  assign unpack_sign = op_a[31] ^ op_b[31];
  assign a_zero      = (op_a[30:23] == 8'd0);
  assign b_zero      = (op_b[30:23] == 8'd0);
  assign exp_calc    = $signed({2'b00, op_a[30:23]}) - $signed({2'b00, op_b[30:23]}) + 10'sd127;
  assign rem_diff    = rem - {2'b00, mant_b};
  assign rem_ge      = (rem >= {2'b00, mant_b});

  // Quotient lies in (0.5, 2): q[25] picks which window holds the 23 fraction bits.
  always_comb begin
    if (quo[25]) begin
      mant_n = quo[24:2];
      exp_n  = exp_r;
    end else begin
      mant_n = quo[23:1];
      exp_n  = exp_r - 10'sd1;
    end
`ifdef DIV_ROUND_NEAREST_EN
    guard    = quo[25] ? quo[1] : quo[0];
    sticky   = (quo[25] & quo[0]) | (|rem);
    round_up = guard & (sticky | mant_n[0]);
    {carry, mant_f} = {1'b0, mant_n} + {23'd0, round_up};
    exp_f    = carry ? (exp_n + 10'sd1) : exp_n;
`else
    mant_f = mant_n;
    exp_f  = exp_n;
`endif
    if (exp_f >= 10'sd255) begin
      norm_res   = {sign, 8'hFF, 23'h0};
      norm_flags = 3'b100;
    end else if (exp_f <= 10'sd0) begin
      norm_res   = {sign, 31'h0};
      norm_flags = 3'b010;
    end else begin
      norm_res   = {sign, exp_f[7:0], mant_f};
      norm_flags = 3'b000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      op_a            <= '0;
      op_b            <= '0;
      sign            <= 1'b0;
      mant_b          <= '0;
      exp_r           <= '0;
      rem             <= '0;
      quo             <= '0;
      cnt             <= '0;
      res_r           <= '0;
      flags_r         <= '0;
      dif.busy        <= 1'b0;
      dif.done        <= 1'b0;
      dif.result      <= '0;
      dif.overflow    <= 1'b0;
      dif.underflow   <= 1'b0;
      dif.div_by_zero <= 1'b0;
    end else begin
      dif.done <= 1'b0;
      case (state)
        IDLE: begin
          if (dif.start) begin
            op_a     <= dif.A;
            op_b     <= dif.B;
            dif.busy <= 1'b1;
            state    <= UNPACK;
          end
        end
        UNPACK: begin
          sign   <= unpack_sign;
          mant_b <= {1'b1, op_b[22:0]};
          exp_r  <= exp_calc;
          rem    <= {2'b01, op_a[22:0]};
          quo    <= '0;
          cnt    <= '0;
          // Zero divisor takes priority over a zero dividend (0/0 reports div_by_zero).
          if (b_zero) begin
            res_r   <= {unpack_sign, 8'hFF, 23'h0};
            flags_r <= 3'b001;
            state   <= DONE;
          end else if (a_zero) begin
            res_r   <= {unpack_sign, 31'h0};
            flags_r <= 3'b000;
            state   <= DONE;
          end else begin
            state   <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (rem_ge) begin
            quo <= {quo[24:0], 1'b1};
            rem <= {rem_diff[24:0], 1'b0};
          end else begin
            quo <= {quo[24:0], 1'b0};
            rem <= {rem[24:0], 1'b0};
          end
          if (cnt == 5'd25) begin
            cnt   <= '0;
            state <= NORM;
          end else begin
            cnt   <= cnt + 5'd1;
          end
        end
        NORM: begin
          res_r   <= norm_res;
          flags_r <= norm_flags;
          state   <= DONE;
        end
        DONE: begin
          dif.busy        <= 1'b0;
          dif.done        <= 1'b1;
          dif.result      <= res_r;
          dif.overflow    <= flags_r[2];
          dif.underflow   <= flags_r[1];
          dif.div_by_zero <= flags_r[0];
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_sequential.sv
// Directed self-checking bench for divider_sequential: latency, results, flags, reset abort.
module tb_divider_sequential;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         n_checks;
  int         n_errors;
  logic [34:0] exp_q[$];

  divider_sequential_if dif ();

  divider_sequential dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dif       (dif),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] observed();
    return {dif.result, dif.overflow, dif.underflow, dif.div_by_zero};
  endfunction

  // Driver: issue one division, optionally poke start again poke_at cycles after acceptance.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [2:0] exp_flags,
                         input int exp_lat, input int poke_at);
    int          lat;
    logic [34:0] exp_v;
    logic [34:0] held;
    exp_q.push_back({exp_res, exp_flags});
    @(negedge clk);
    dif.A     = a;
    dif.B     = b;
    dif.start = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    check_val({tag, "_busy_accept"}, {63'd0, dif.busy}, 64'd1);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (poke_at != 0 && n == poke_at + 1) dif.start = 1'b0;
      if (poke_at != 0 && n == poke_at) begin
        dif.A     = 32'h3F800000;
        dif.B     = 32'h40800000;
        dif.start = 1'b1;
      end
      if (dif.done) begin
        lat = n;
        break;
      end
    end
    dif.start = 1'b0;
    check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    exp_v = exp_q.pop_front();
    check_val({tag, "_result"}, {29'd0, observed()}, {29'd0, exp_v});
    check_val({tag, "_busy_at_done"}, {63'd0, dif.busy}, 64'd0);
    held = observed();
    @(posedge clk);
    #1;
    check_val({tag, "_after_done"}, {61'd0, dif.done, dif.busy, 1'b0},
              64'd0);
    check_val({tag, "_held"}, {29'd0, observed()}, {29'd0, held});
  endtask

  initial begin
    logic saw_done;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    dif.start = 1'b0;
    dif.A     = '0;
    dif.B     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", {27'd0, dif.busy, dif.done, observed()}, 64'd0);
    check_val("reset_state", {61'd0, dbg_state}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_div("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 29, 0);
`ifdef DIV_ROUND_NEAREST_EN
    run_div("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 29, 0);
    run_div("two_by_m3",    32'h40000000, 32'hC0400000, 32'hBF2AAAAB, 3'b000, 29, 0);
`else
    run_div("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 29, 0);
    run_div("two_by_m3",    32'h40000000, 32'hC0400000, 32'hBF2AAAAA, 3'b000, 29, 0);
`endif
    run_div("div_zero",     32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, 2, 1);
    run_div("ovf",          32'h7F000000, 32'h00800000, 32'h7F800000, 3'b100, 29, 0);
    run_div("unf",          32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 29, 0);
    run_div("unf_norm",     32'h00800000, 32'h3FC00000, 32'h00000000, 3'b010, 29, 0);
    run_div("max_finite",   32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 3'b000, 29, 0);
    run_div("one_busy_poke",32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 29, 5);
    run_div("neg_half",     32'hBF800000, 32'h40000000, 32'hBF000000, 3'b000, 29, 0);
    run_div("three_by_two", 32'h40400000, 32'h40000000, 32'h3FC00000, 3'b000, 29, 0);
    run_div("neg_zero_a",   32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 2, 0);
    run_div("denorm_a",     32'h00400000, 32'h40000000, 32'h00000000, 3'b000, 2, 0);
    run_div("neg_div_zero", 32'hC0000000, 32'h00000000, 32'hFF800000, 3'b001, 2, 0);
    run_div("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7F800000, 3'b001, 2, 0);

    // Reset abort mid-division
    @(negedge clk);
    dif.A     = 32'hC0C00000;
    dif.B     = 32'h40000000;
    dif.start = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    saw_done  = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (dif.done) saw_done = 1'b1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_outputs", {27'd0, dif.busy, dif.done, observed()}, 64'd0);
    check_val("abort_state", {61'd0, dbg_state}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (dif.done) saw_done = 1'b1;
    end
    check_val("abort_no_done", {63'd0, saw_done}, 64'd0);
    check_val("abort_quiet", {27'd0, dif.busy, dif.done, observed()}, 64'd0);
    run_div("after_reset", 32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000, 29, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
